// File: rtl/tuart_tx_arb.sv
// tuart_tx_arb: round-robin arbiter and word serialiser for the Tiny-UART TX path.
// Shares one DATA_BITS-wide transmitter between N_REQ requesters, LSB chunk first.
//
// Ports:
//   clk_i        system clock
//   rst_in       asynchronous active-low reset
//   req_valid_i  per-requester word valid, held until matching ready
//   req_data_i   flattened words, requester k at [k*CMD_WIDTH +: CMD_WIDTH]
//   req_ready_o  registered one-cycle acknowledge (word captured at that edge)
//   grant_o      one-hot owner of the word in flight, zero in IDLE
//   tx_data_o    chunk presented to the transmitter, held until next strobe
//   tx_stb_o     registered one-cycle transmit strobe
//   tx_busy_i    transmitter busy
//   idle_o       high while the FSM is in IDLE
//
// Configuration macro: TUART_TX_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest asserted index wins
//   undefined -> round-robin starting after the last served requester
module tuart_tx_arb #(
    parameter int N_REQ     = 2,
    parameter int CMD_WIDTH = 32,
    parameter int DATA_BITS = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_in,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ*CMD_WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [N_REQ-1:0]           grant_o,
    output logic [DATA_BITS-1:0]       tx_data_o,
    output logic                       tx_stb_o,
    input  logic                       tx_busy_i,
    output logic                       idle_o
);

    localparam int NCHUNK = CMD_WIDTH / DATA_BITS;
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam int IW     = $clog2(N_REQ);
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    generate
        if (CMD_WIDTH % DATA_BITS != 0) begin : g_chk_width
            $error("tuart_tx_arb: CMD_WIDTH must be a multiple of DATA_BITS");
        end
        if (N_REQ < 2) begin : g_chk_nreq
            $error("tuart_tx_arb: N_REQ must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_ACK,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [CMD_WIDTH-1:0]   r_word;
    logic [CW-1:0]          r_chunk;
    logic [N_REQ-1:0]       r_grant;
    logic [N_REQ-1:0]       r_ready;
    logic [DATA_BITS-1:0]   r_tx_data;
    logic                   r_stb;

    logic [CMD_WIDTH-1:0]   w_word_nxt;
    logic [CW-1:0]          w_chunk_nxt;
    logic [N_REQ-1:0]       w_grant_nxt;
    logic [N_REQ-1:0]       w_ready_nxt;
    logic [DATA_BITS-1:0]   w_tx_data_nxt;
    logic                   w_stb_nxt;

    logic                   w_any;
    logic [IW-1:0]          w_win;

`ifndef TUART_TX_ARB_FIXED_PRIO_EN
    logic [IW-1:0]          r_last;
    logic [IW-1:0]          r_owner;
    logic [IW-1:0]          w_last_nxt;
    logic [IW-1:0]          w_owner_nxt;
`endif

    // Winner search. The loop runs from the far end down so the candidate
    // closest to the search start is the last one written and wins.
    always_comb begin : p_arb
        int k;
        k     = 0;
        w_any = 1'b0;
        w_win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
`ifdef TUART_TX_ARB_FIXED_PRIO_EN
            k = i;
`else
            k = (int'(r_last) + 1 + i) % N_REQ;
`endif
            if (|(req_valid_i & (N_REQ'(1) << k))) begin
                w_any = 1'b1;
                w_win = IW'(k);
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_any)      w_state_nxt = S_SEND;
            S_SEND: if (!tx_busy_i) w_state_nxt = S_ACK;
            S_ACK:  if (tx_busy_i)  w_state_nxt = S_DONE;
            S_DONE: begin
                if (!tx_busy_i) begin
                    if (r_chunk == LAST_CHUNK) w_state_nxt = S_IDLE;
                    else                       w_state_nxt = S_SEND;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values; registered below
    always_comb begin
        w_word_nxt    = r_word;
        w_chunk_nxt   = r_chunk;
        w_grant_nxt   = r_grant;
        w_ready_nxt   = '0;
        w_tx_data_nxt = r_tx_data;
        w_stb_nxt     = 1'b0;
`ifndef TUART_TX_ARB_FIXED_PRIO_EN
        w_last_nxt    = r_last;
        w_owner_nxt   = r_owner;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_word_nxt  = CMD_WIDTH'(req_data_i >> (int'(w_win) * CMD_WIDTH));
                    w_grant_nxt = N_REQ'(1) << w_win;
                    w_ready_nxt = N_REQ'(1) << w_win;
                    w_chunk_nxt = '0;
`ifndef TUART_TX_ARB_FIXED_PRIO_EN
                    w_owner_nxt = w_win;
`endif
                end
            end
            S_SEND: begin
                if (!tx_busy_i) begin
                    w_tx_data_nxt = DATA_BITS'(r_word >> (int'(r_chunk) * DATA_BITS));
                    w_stb_nxt     = 1'b1;
                end
            end
            S_ACK: begin
            end
            S_DONE: begin
                if (!tx_busy_i) begin
                    if (r_chunk == LAST_CHUNK) begin
                        w_grant_nxt = '0;
`ifndef TUART_TX_ARB_FIXED_PRIO_EN
                        w_last_nxt  = r_owner;
`endif
                    end else begin
                        w_chunk_nxt = r_chunk + CW'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_word    <= '0;
            r_chunk   <= '0;
            r_grant   <= '0;
            r_ready   <= '0;
            r_tx_data <= '0;
            r_stb     <= 1'b0;
`ifndef TUART_TX_ARB_FIXED_PRIO_EN
            r_last    <= IW'(N_REQ - 1);
            r_owner   <= '0;
`endif
        end else begin
            r_word    <= w_word_nxt;
            r_chunk   <= w_chunk_nxt;
            r_grant   <= w_grant_nxt;
            r_ready   <= w_ready_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_stb     <= w_stb_nxt;
`ifndef TUART_TX_ARB_FIXED_PRIO_EN
            r_last    <= w_last_nxt;
            r_owner   <= w_owner_nxt;
`endif
        end
    end

    assign req_ready_o = r_ready;
    assign grant_o     = r_grant;
    assign tx_data_o   = r_tx_data;
    assign tx_stb_o    = r_stb;
    assign idle_o      = (r_state == S_IDLE);

endmodule

// File: tb/tb_tuart_tx_arb.sv
// tb_tuart_tx_arb: self-checking bench for tuart_tx_arb.
// Default instance (N_REQ=2, 32/8) plus a 3-requester 16/8 instance.
module tb_tuart_tx_arb;

    typedef struct {
        logic [7:0] data;
        logic [2:0] grant;
    } exp_t;

    typedef struct {
        int          req;
        logic [31:0] word;
        logic [1:0]  exp_rdy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [63:0] req_data = '0;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_stb;
    logic        tx_busy;
    logic        idle;
    logic        force_busy = 1'b0;
    int          bcnt;

    logic [2:0]  req_valid3 = '0;
    logic [47:0] req_data3 = '0;
    logic [2:0]  req_ready3;
    logic [2:0]  grant3;
    logic [7:0]  tx_data3;
    logic        tx_stb3;
    logic        tx_busy3;
    logic        idle3;
    int          bcnt3;

    exp_t sbq[$];
    exp_t sb3[$];

    int n_checks = 0;
    int n_fail   = 0;
    int stb_cnt  = 0;
    int rdy_cnt  = 0;
    int stb3_cnt = 0;

    always #5 clk = ~clk;

    tuart_tx_arb dut (
        .clk_i       (clk),
        .rst_in      (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .grant_o     (grant),
        .tx_data_o   (tx_data),
        .tx_stb_o    (tx_stb),
        .tx_busy_i   (tx_busy),
        .idle_o      (idle)
    );

    tuart_tx_arb #(
        .N_REQ     (3),
        .CMD_WIDTH (16),
        .DATA_BITS (8)
    ) dut3 (
        .clk_i       (clk),
        .rst_in      (rst_n),
        .req_valid_i (req_valid3),
        .req_data_i  (req_data3),
        .req_ready_o (req_ready3),
        .grant_o     (grant3),
        .tx_data_o   (tx_data3),
        .tx_stb_o    (tx_stb3),
        .tx_busy_i   (tx_busy3),
        .idle_o      (idle3)
    );

    // Transmitter models: busy for 10 cycles after each strobe
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           bcnt <= 0;
        else if (tx_stb)      bcnt <= 10;
        else if (bcnt != 0)   bcnt <= bcnt - 1;
    end
    assign tx_busy = force_busy | (bcnt != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           bcnt3 <= 0;
        else if (tx_stb3)     bcnt3 <= 10;
        else if (bcnt3 != 0)  bcnt3 <= bcnt3 - 1;
    end
    assign tx_busy3 = (bcnt3 != 0);

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (req_ready != 0) begin
                rdy_cnt <= rdy_cnt + 1;
                check("ready_onehot", 64'($countones(req_ready)), 1);
                check("ready_eq_grant", req_ready, grant);
            end
            if (tx_stb) begin
                stb_cnt <= stb_cnt + 1;
                if (sbq.size() == 0) begin
                    check("unexpected_stb", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("stb_data", tx_data, e.data);
                    check("stb_grant", grant, e.grant[1:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && tx_stb3) begin
            stb3_cnt <= stb3_cnt + 1;
            if (sb3.size() == 0) begin
                check("unexpected_stb3", 1, 0);
            end else begin
                e = sb3.pop_front();
                check("stb3_data", tx_data3, e.data);
                check("stb3_grant", grant3, e.grant);
            end
        end
    end

    function automatic logic [31:0] wd(input int k, input int n);
        wd = {8'(8'h10 * k + n), 8'h5A, 8'(n + 1), 8'(8'hE0 + k)};
    endfunction

    task automatic push_word(input logic [31:0] w, input logic [2:0] g);
        for (int i = 0; i < 4; i++) sbq.push_back('{data: w[8*i +: 8], grant: g});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (idle) break;
        end
        check(nm, idle, 1);
    endtask

    task automatic run_word(input int req, input logic [31:0] w,
                            input logic [1:0] exp_rdy);
        int s0;
        int r0;
        s0 = stb_cnt;
        r0 = rdy_cnt;
        push_word(w, 3'(exp_rdy));
        @(negedge clk);
        req_data[req*32 +: 32] = w;
        req_valid[req] = 1'b1;
        @(negedge clk);
        check("ready_lat", req_ready, exp_rdy);
        check("grant_lat", grant, exp_rdy);
        check("idle_low", idle, 0);
        req_valid = '0;
        @(negedge clk);
        check("stb_lat", tx_stb, 1);
        wait_idle("word_idle", 400);
        check("word_strobes", 64'(stb_cnt - s0), 4);
        check("word_readies", 64'(rdy_cnt - r0), 1);
        check("grant_cleared", grant, 0);
        check("busy_fell", tx_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int exp_order[4];
        int used[2];
        int cnt[2];
        int idx;
        int got;
        int s0;
        int r0;

        vecs[0] = '{req: 0, word: 32'hA1B2C3D4, exp_rdy: 2'b01};
        vecs[1] = '{req: 1, word: 32'h0F0F0F0F, exp_rdy: 2'b10};
        vecs[2] = '{req: 0, word: 32'hFFFFFFFF, exp_rdy: 2'b01};
        vecs[3] = '{req: 1, word: 32'h00000000, exp_rdy: 2'b10};
`ifdef TUART_TX_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif

        // Asynchronous reset values
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_grant", grant, 0);
        check("rst_data", tx_data, 0);
        check("rst_stb", tx_stb, 0);
        check("rst_idle", idle, 1);
        check("rst_grant3", grant3, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single-word transfers from the vector table
        for (int v = 0; v < 4; v++) run_word(vecs[v].req, vecs[v].word, vecs[v].exp_rdy);

        // Contention straight after reset, both held for 4 words
        do_reset();
        used = '{0, 0};
        for (int p = 0; p < 4; p++) begin
            push_word(wd(exp_order[p], used[exp_order[p]]), 3'(1 << exp_order[p]));
            used[exp_order[p]]++;
        end
        cnt = '{0, 0};
        s0 = stb_cnt;
        req_data = {wd(1, 0), wd(0, 0)};
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            got = 0;
            for (int t = 0; t < 400; t++) begin
                @(negedge clk);
                if (req_ready != 0) begin
                    got = 1;
                    break;
                end
            end
            check("rr_ready_seen", got, 1);
            idx = req_ready[1] ? 1 : 0;
            check("rr_order", idx, exp_order[n]);
            cnt[idx]++;
            req_data[idx*32 +: 32] = wd(idx, cnt[idx]);
            if (n == 3) req_valid = '0;
        end
        wait_idle("rr_idle", 400);
        check("rr_strobes", 64'(stb_cnt - s0), 16);
        check("rr_sb_empty", sbq.size(), 0);

        // Transmitter busy before the request
        s0 = stb_cnt;
        push_word(32'h11223344, 3'b010);
        @(negedge clk);
        force_busy = 1'b1;
        req_data[63:32] = 32'h11223344;
        req_valid = 2'b10;
        @(negedge clk);
        check("busy_ready", req_ready, 2'b10);
        req_valid = '0;
        repeat (20) @(negedge clk);
        check("busy_no_stb", 64'(stb_cnt - s0), 0);
        check("busy_not_idle", idle, 0);
        force_busy = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_one_stb", 64'(stb_cnt - s0), 1);
        wait_idle("busy_idle", 400);
        check("busy_strobes", 64'(stb_cnt - s0), 4);

        // Reset after the second strobe of a word
        s0 = stb_cnt;
        push_word(32'hCAFEF00D, 3'b001);
        @(negedge clk);
        req_data[31:0] = 32'hCAFEF00D;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = '0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            #1;
            if (stb_cnt - s0 >= 2) break;
        end
        check("mid_two_stb", 64'(stb_cnt - s0), 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stb", tx_stb, 0);
        check("mid_rst_data", tx_data, 0);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_idle", idle, 1);
        sbq.delete();
        r0 = rdy_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("mid_no_more_stb", 64'(stb_cnt - s0), 2);
        check("mid_no_ready", 64'(rdy_cnt - r0), 0);
        check("mid_idle", idle, 1);

        // Three requesters, 16-bit words, req2 only
        sb3.push_back('{data: 8'hEF, grant: 3'b100});
        sb3.push_back('{data: 8'hBE, grant: 3'b100});
        @(negedge clk);
        req_data3[47:32] = 16'hBEEF;
        req_valid3 = 3'b100;
        @(negedge clk);
        check("p3_ready", req_ready3, 3'b100);
        check("p3_grant", grant3, 3'b100);
        req_valid3 = '0;
        got = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (idle3) begin
                got = 1;
                break;
            end
        end
        check("p3_idle", got, 1);
        check("p3_strobes", stb3_cnt, 2);
        check("p3_grant_clr", grant3, 0);

        check("sb_empty", sbq.size(), 0);
        check("sb3_empty", sb3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
